// File: rtl/morse_pkg.sv
// Shared constants, slot helpers and FSM state type for the Morse keyer.
package morse_pkg;

  localparam int unsigned SYM_W      = 3;
  localparam int unsigned SLOT_N     = 8;
  localparam int unsigned WORD_W     = SYM_W * SLOT_N;
  localparam int unsigned SLOT_IDX_W = $clog2(SLOT_N);
  localparam int unsigned UNIT_W     = 3;
  localparam int unsigned LAST_BIT   = 2;

  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(SLOT_N - 1);

  localparam logic [1:0] CODE_DOT   = 2'b10;
  localparam logic [1:0] CODE_DASH  = 2'b11;
  localparam logic [1:0] CODE_EMPTY = 2'b00;

  localparam logic [UNIT_W-1:0] UNITS_DOT        = UNIT_W'(1);
  localparam logic [UNIT_W-1:0] UNITS_DASH       = UNIT_W'(3);
  localparam logic [UNIT_W-1:0] UNITS_IGAP       = UNIT_W'(1);
  localparam logic [UNIT_W-1:0] UNITS_CGAP       = UNIT_W'(3);
  localparam logic [UNIT_W-1:0] UNITS_WGAP_EXTRA = UNIT_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MARK = 3'd1,
    ST_IGAP = 3'd2,
    ST_SKIP = 3'd3,
    ST_WGAP = 3'd4,
    ST_CGAP = 3'd5
  } state_e;

  function automatic logic [1:0] slot_code(input logic [SYM_W-1:0] s);
    return s[1:0];
  endfunction

  function automatic logic slot_last(input logic [SYM_W-1:0] s);
    return s[LAST_BIT];
  endfunction

endpackage

// File: rtl/morse_unit_timer.sv
// Prescaler plus unit down-counter; done flags the final cycle of a loaded interval.
module morse_unit_timer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [UNIT_W-1:0] units,
  output logic              done
);

  localparam int unsigned PRESC_W = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(UNIT_CYCLES - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [UNIT_W-1:0]  r_units;
  logic               w_wrap;

  assign w_wrap = (r_presc == PRESC_MAX);
  assign done   = w_wrap && (r_units == UNIT_W'(1));

  // Counters stall once the unit count has drained to zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_units <= '0;
    end else if (load) begin
      r_presc <= '0;
      r_units <= units;
    end else if (r_units != '0) begin
      if (w_wrap) begin
        r_presc <= '0;
        r_units <= r_units - UNIT_W'(1);
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/morse_keyer.sv
// Serialises one packed Morse word per handshake into an on/off key.
// Optional sidetone output enabled by MORSE_KEYER_SIDETONE_EN.
module morse_keyer
  import morse_pkg::*;
#(
  parameter int unsigned UNIT_CYCLES = 16
`ifdef MORSE_KEYER_SIDETONE_EN
  , parameter int unsigned TONE_HALF = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WORD_W-1:0] morse_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              key_out,
  output logic              busy,
`ifdef MORSE_KEYER_SIDETONE_EN
  output logic              tone_out,
`endif
  output logic              sym_err
);

  state_e                r_state;
  state_e                w_next_state;
  state_e                w_dec_state;
  logic [WORD_W-1:0]     r_shift;
  logic [WORD_W-1:0]     w_word;
  logic [SLOT_IDX_W-1:0] r_slot_idx;
  logic [SLOT_IDX_W-1:0] w_idx;
  logic [SYM_W-1:0]      w_slot;
  logic [1:0]            w_code;
  logic                  w_slot_last;
  logic                  w_fresh;
  logic                  r_marked;
  logic                  w_marked;
  logic                  r_last;
  logic                  r_key;
  logic                  r_ready;
  logic                  r_busy;
  logic                  r_err;
  logic                  w_decode;
  logic                  w_illegal;
  logic                  w_is_mark;
  logic                  w_load;
  logic                  w_done;
  logic [UNIT_W-1:0]     w_units;
  logic [UNIT_W-1:0]     w_dec_units;

  assign in_ready = r_ready;
  assign busy     = r_busy;
  assign key_out  = r_key;
  assign sym_err  = r_err;

  // In IDLE the decoder looks straight at the offered word (decode on acceptance).
  assign w_fresh     = (r_state == ST_IDLE);
  assign w_word      = w_fresh ? morse_in : r_shift;
  assign w_idx       = w_fresh ? '0 : r_slot_idx;
  assign w_marked    = w_fresh ? 1'b0 : r_marked;
  assign w_slot      = w_word[WORD_W-1 -: SYM_W];
  assign w_code      = slot_code(w_slot);
  assign w_slot_last = slot_last(w_slot);

  morse_unit_timer #(
    .UNIT_CYCLES (UNIT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .units (w_units),
    .done  (w_done)
  );

  // Slot decoder: anything not explicitly legal falls through to an error CGAP.
  always_comb begin
    w_dec_state = ST_CGAP;
    w_dec_units = UNITS_CGAP;
    w_illegal   = 1'b1;
    w_is_mark   = 1'b0;
    if (!((w_idx == LAST_SLOT) && !w_slot_last)) begin
      case (w_code)
        CODE_DOT: begin
          w_dec_state = ST_MARK;
          w_dec_units = UNITS_DOT;
          w_illegal   = 1'b0;
          w_is_mark   = 1'b1;
        end
        CODE_DASH: begin
          w_dec_state = ST_MARK;
          w_dec_units = UNITS_DASH;
          w_illegal   = 1'b0;
          w_is_mark   = 1'b1;
        end
        CODE_EMPTY: begin
          if (!w_marked) begin
            w_illegal = 1'b0;
            if (w_slot_last) begin
              w_dec_state = ST_WGAP;
              w_dec_units = UNITS_WGAP_EXTRA;
            end else begin
              w_dec_state = ST_SKIP;
              w_dec_units = '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_units      = '0;
    w_decode     = 1'b0;
    case (r_state)
      ST_IDLE: w_decode = in_valid;
      ST_MARK: begin
        if (w_done) begin
          w_load = 1'b1;
          if (r_last) begin
            w_next_state = ST_CGAP;
            w_units      = UNITS_CGAP;
          end else begin
            w_next_state = ST_IGAP;
            w_units      = UNITS_IGAP;
          end
        end
      end
      ST_IGAP: w_decode = w_done;
      ST_SKIP: w_decode = 1'b1;
      ST_WGAP: begin
        if (w_done) begin
          w_next_state = ST_CGAP;
          w_units      = UNITS_CGAP;
          w_load       = 1'b1;
        end
      end
      ST_CGAP: begin
        if (w_done) begin
          w_next_state = ST_IDLE;
          w_load       = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
    if (w_decode) begin
      w_next_state = w_dec_state;
      w_units      = w_dec_units;
      w_load       = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shift    <= '0;
      r_slot_idx <= '0;
      r_marked   <= 1'b0;
      r_last     <= 1'b0;
      r_key      <= 1'b0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_key   <= (w_next_state == ST_MARK);
      r_ready <= (w_next_state == ST_IDLE);
      r_busy  <= (w_next_state != ST_IDLE);
      r_err   <= w_decode && w_illegal;
      if (w_decode) begin
        r_shift    <= {w_word[WORD_W-SYM_W-1:0], {SYM_W{1'b0}}};
        r_slot_idx <= w_idx + SLOT_IDX_W'(1);
        r_marked   <= w_marked | w_is_mark;
        r_last     <= w_slot_last;
      end
    end
  end

`ifdef MORSE_KEYER_SIDETONE_EN
  localparam int unsigned TONE_W = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;
  localparam logic [TONE_W-1:0] TONE_MAX = TONE_W'(TONE_HALF - 1);

  logic [TONE_W-1:0] r_tone_cnt;
  logic              r_tone;

  assign tone_out = r_tone;

  // Tone runs only while staying in MARK, so every mark entry restarts low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end else if ((r_state == ST_MARK) && (w_next_state == ST_MARK)) begin
      if (r_tone_cnt == TONE_MAX) begin
        r_tone_cnt <= '0;
        r_tone     <= ~r_tone;
      end else begin
        r_tone_cnt <= r_tone_cnt + TONE_W'(1);
      end
    end else begin
      r_tone_cnt <= '0;
      r_tone     <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_morse_keyer.sv
// Self-checking bench for morse_keyer at UNIT_CYCLES = 4 (TONE_HALF = 2 with sidetone).
module tb_morse_keyer;

  localparam int unsigned U = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [23:0] morse_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        key_out;
  logic        busy;
  logic        sym_err;
`ifdef MORSE_KEYER_SIDETONE_EN
  logic        tone_out;
`endif

  always #5 clk = ~clk;

  morse_keyer #(
    .UNIT_CYCLES (U)
`ifdef MORSE_KEYER_SIDETONE_EN
    , .TONE_HALF (2)
`endif
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .morse_in (morse_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .key_out  (key_out),
    .busy     (busy),
`ifdef MORSE_KEYER_SIDETONE_EN
    .tone_out (tone_out),
`endif
    .sym_err  (sym_err)
  );

  // Expected per-word observations, cycles counted from the transfer edge (cycle 0).
  typedef struct {
    logic [23:0] word;
    bit          noise;
    int          kc;
    int          kf;
    int          kl;
    int          kr;
    int          fall;
    int          r2;
    int          ec;
    int          ecyc;
    int          rdy;
  } vec_t;

  vec_t vecs[15];
  vec_t sb[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_word(input vec_t v, input string tag);
    int   kc = 0, kf = 0, kl = 0, kr = 0, fall = 0, r2 = 0;
    int   ec = 0, ecyc = 0, rdy = 0, busy_bad = 0, th = 0, tbad = 0;
    logic kp = 1'b0;
    vec_t e;
    for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
    check({tag, "_ready_before"}, int'(in_ready), 1);
    morse_in = v.word;
    in_valid = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      if (n == 1) begin
        in_valid = v.noise;
        if (v.noise) morse_in = 24'($urandom);
      end
      if (key_out) begin
        kc++;
        if (kf == 0) kf = n;
        kl = n;
        if (!kp) begin
          kr++;
          if (kr == 2) r2 = n;
        end
      end else if (kf != 0 && fall == 0) begin
        fall = n;
      end
      kp = key_out;
      if (sym_err) begin
        ec++;
        if (ecyc == 0) ecyc = n;
      end
      if (busy == in_ready) busy_bad++;
`ifdef MORSE_KEYER_SIDETONE_EN
      if (tone_out) begin
        th++;
        if (!key_out) tbad++;
      end
`endif
      if (in_ready) begin
        rdy = n;
        break;
      end
    end
    in_valid = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({tag, "_key_cycles"}, kc, e.kc);
      check({tag, "_key_first"}, kf, e.kf);
      check({tag, "_key_last"}, kl, e.kl);
      check({tag, "_key_rises"}, kr, e.kr);
      check({tag, "_key_fall1"}, fall, e.fall);
      check({tag, "_key_rise2"}, r2, e.r2);
      check({tag, "_err_count"}, ec, e.ec);
      check({tag, "_err_cycle"}, ecyc, e.ecyc);
      check({tag, "_ready_cycle"}, rdy, e.rdy);
      check({tag, "_busy_vs_ready"}, busy_bad, 0);
`ifdef MORSE_KEYER_SIDETONE_EN
      check({tag, "_tone_high"}, th, e.kc / 2);
      check({tag, "_tone_no_key"}, tbad, 0);
`endif
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           word        nz  kc kf kl kr fall r2 ec ecyc rdy
    vecs[0]  = '{24'hC00000, 1'b0,  4, 1,  4, 1,  5,  0, 0,  0, 17}; // E
    vecs[1]  = '{24'h5C0000, 1'b0, 16, 1, 20, 2,  5,  9, 0,  0, 33}; // A
    vecs[2]  = '{24'h100000, 1'b0,  0, 0,  0, 0,  0,  0, 0,  0, 30}; // space
    vecs[3]  = '{24'hC00000, 1'b0,  4, 1,  4, 1,  5,  0, 0,  0, 17}; // E right after space
    vecs[4]  = '{24'h200000, 1'b0,  0, 0,  0, 0,  0,  0, 1,  1, 13}; // 01 code in slot 0
    vecs[5]  = '{24'h000000, 1'b0,  0, 0,  0, 0,  0,  0, 1,  8, 20}; // all empty
    vecs[6]  = '{24'hE00000, 1'b0, 12, 1, 12, 1, 13,  0, 0,  0, 25}; // T
    vecs[7]  = '{24'h780000, 1'b0, 16, 1, 20, 2, 13, 17, 0,  0, 33}; // N
    vecs[8]  = '{24'h492496, 1'b0, 32, 1, 60, 8,  5,  9, 0,  0, 73}; // 8 dots, LAST on slot 7
    vecs[9]  = '{24'h492494, 1'b0, 28, 1, 52, 7,  5,  9, 1, 57, 69}; // 7 dots then empty+LAST
    vecs[10] = '{24'h440000, 1'b0,  4, 1,  4, 1,  5,  0, 1,  9, 21}; // dot then 01 code
    vecs[11] = '{24'h0A0000, 1'b0,  4, 2,  5, 1,  6,  0, 1, 10, 22}; // skip, dot, empty
    vecs[12] = '{24'h000006, 1'b0,  4, 8, 11, 1, 12,  0, 0,  0, 24}; // dot+LAST in slot 7
    vecs[13] = '{24'h000002, 1'b0,  0, 0,  0, 0,  0,  0, 1,  8, 20}; // slot 7 without LAST
    vecs[14] = '{24'hC00000, 1'b1,  4, 1,  4, 1,  5,  0, 0,  0, 17}; // E with busy-time noise

    rst_n    = 1'b0;
    in_valid = 1'b0;
    morse_in = '0;
    repeat (3) @(negedge clk);
    check("rst_key", int'(key_out), 0);
    check("rst_ready", int'(in_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_err", int'(sym_err), 0);
`ifdef MORSE_KEYER_SIDETONE_EN
    check("rst_tone", int'(tone_out), 0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) run_word(vecs[i], $sformatf("v%0d", i));

    // Reset pulse in the middle of a dash.
    for (int w = 0; w < 200 && !in_ready; w++) @(negedge clk);
    morse_in = 24'hE00000;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_dash_key", int'(key_out), 1);
    check("mid_dash_busy", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_key", int'(key_out), 0);
    check("mid_rst_ready", int'(in_ready), 1);
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_err", int'(sym_err), 0);
`ifdef MORSE_KEYER_SIDETONE_EN
    check("mid_rst_tone", int'(tone_out), 0);
`endif
    rst_n = 1'b1;
    run_word(vecs[0], "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
